// File: rtl/up_down_cntr_pkg.sv
// Shared definitions for the up/down modulus counter: direction encoding and
// the terminal-value helper used to size the compare constant.
package up_down_cntr_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest count value (MODULUS-1), truncated to the counter width.
  function automatic logic [31:0] cntr_max(input longint modulus, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return 32'(modulus - 1) & mask;
  endfunction

endpackage

// File: rtl/up_down_next_state.sv
// Combinational next-value and terminal-count logic for the modulus counter.
// Priority: load > count enable > hold; clear is applied by the parent.
module up_down_next_state
  import up_down_cntr_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             dir_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cntr_max(MODULUS, WIDTH));

  logic at_max;
  logic at_min;

  assign at_max = (q_i == CNT_MAX);
  assign at_min = (q_i == '0);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q_next_o = q_i;
    tc_o     = 1'b0;
    if (load_i) begin
      q_next_o = (d_i > CNT_MAX) ? CNT_MAX : d_i;
    end else if (en_i) begin
      case (dir_i)
        DIR_UP: begin
          tc_o = at_max;
          if (!at_max)       q_next_o = q_i + WIDTH'(1);
          else if (!SATURATE) q_next_o = '0;
        end
        DIR_DOWN: begin
          tc_o = at_min;
          if (!at_min)       q_next_o = q_i - WIDTH'(1);
          else if (!SATURATE) q_next_o = CNT_MAX;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/up_down_mod_counter.sv
// Parametrised up/down modulus counter with load, enable, terminal count and
// optional saturation; tc is meant to drive the enable of a cascaded stage.
module up_down_mod_counter
  import up_down_cntr_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up_or_DownBar,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (longint'(1) << WIDTH)) begin : g_bad_params
      $error("up_down_mod_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_raw;

  up_down_next_state #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next_state (
    .q_i      (cnt_q),
    .dir_i    (up_or_DownBar),
    .en_i     (en),
    .load_i   (load),
    .d_i      (d),
    .q_next_o (cnt_d),
    .tc_o     (tc_raw)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q  = cnt_q;
  assign tc = tc_raw & ~clear;

endmodule
